rom_load_seq: RTL and testbench

Download sequencer between the HPS ioctl stream and the arcade core's ROM write port. It registers and decodes each downloaded byte into a region-tagged write, counts bytes, and holds the core in reset for the whole load and a settle period afterwards. It releases the core only when the expected byte count arrived; otherwise it latches an error. It replaces the raw `ioctl_download`-ORed reset path in the top level.

---
 rtl/rom_load_pkg.sv | 29 ++
 rtl/rom_load_seq_if.sv | 23 ++
 rtl/rom_load_settle_ctr.sv | 26 ++
 rtl/rom_load_seq.sv | 150 +++++++++++++++
 tb/tb_rom_load_seq.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rom_load_pkg.sv
// Shared types and ROM region map for the ioctl download sequencer.
// Region table maps the 16-bit image address onto the core's four ROM banks.
package rom_load_pkg;

    typedef enum logic [2:0] {
        S_WAIT,
        S_LOAD,
        S_SETTLE,
        S_RUN,
        S_FAIL
    } load_state_t;

    localparam logic [15:0] REGION_BASE_PROG   = 16'h0000;
    localparam logic [15:0] REGION_BASE_TILES  = 16'h6000;
    localparam logic [15:0] REGION_BASE_SPRITE = 16'h8000;
    localparam logic [15:0] REGION_BASE_PCM    = 16'hA000;

    function automatic logic [1:0] region_of(input logic [15:0] addr);
        if (addr >= REGION_BASE_PCM)
            return 2'd3;
        else if (addr >= REGION_BASE_SPRITE)
            return 2'd2;
        else if (addr >= REGION_BASE_TILES)
            return 2'd1;
        else
            return 2'd0;
    endfunction

endpackage

// File: rtl/rom_load_seq_if.sv
// ioctl byte stream in, decoded ROM write port out.
// master = download source / ROM consumer, slave = the sequencer.
interface rom_load_seq_if;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;

    logic [15:0] dn_addr;
    logic [7:0]  dn_data;
    logic        dn_wr;
    logic [1:0]  dn_region;

    modport master (
        output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
        input  dn_addr, dn_data, dn_wr, dn_region
    );

    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
        output dn_addr, dn_data, dn_wr, dn_region
    );
endinterface

// File: rtl/rom_load_settle_ctr.sv
// Loadable down-counter that parks at zero; used to stretch a reset after an event.
// zero is high whenever the count is exhausted, including out of reset.
module rom_load_settle_ctr #(
    parameter int unsigned WIDTH = 10
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] init,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk_sys) begin
        if (reset)
            count <= '0;
        else if (load)
            count <= init;
        else if (count != '0)
            count <= count - 1'b1;
    end

    assign zero = (count == '0);

endmodule

// File: rtl/rom_load_seq.sv
// ROM download sequencer: decodes ioctl bytes into region-tagged writes and
// holds the core in reset until a complete image has settled.
// Optional checksum gate: define ROM_LOAD_CHECKSUM_EN.
//
// state    | meaning
// ---------+-----------------------------------------------
// S_WAIT   | out of reset, no image loaded yet
// S_LOAD   | download window open, bytes being written
// S_SETTLE | window closed, core reset still held
// S_RUN    | image good, core reset follows user_reset
// S_FAIL   | image short / overflowed / bad sum, core held
module rom_load_seq
    import rom_load_pkg::*;
#(
    parameter int unsigned EXPECT_BYTES  = 49152,
    parameter int unsigned SETTLE_CYCLES = 1024
`ifdef ROM_LOAD_CHECKSUM_EN
    ,
    parameter logic [7:0]  EXPECT_SUM    = 8'h00
`endif
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        user_reset,
    rom_load_seq_if.slave bus,
    output logic        core_reset,
    output logic        load_done,
    output logic        load_error,
    output logic [16:0] byte_count
`ifdef ROM_LOAD_CHECKSUM_EN
    ,
    output logic [7:0]  checksum
`endif
);

    localparam int unsigned CTR_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CTR_W-1:0] SETTLE_INIT  = CTR_W'(SETTLE_CYCLES - 1);
    localparam logic [24:0]      ADDR_LIMIT   = 25'(EXPECT_BYTES);
    localparam logic [16:0]      EXPECT_COUNT = 17'(EXPECT_BYTES);
    localparam logic [16:0]      COUNT_MAX    = '1;

    load_state_t state;
    logic        dl_q;
    logic        ovf;
    logic        dl_rise;
    logic        dl_fall;
    logic        strobe;
    logic        in_range;
    logic        ctr_load;
    logic        ctr_zero;
    logic        image_ok;

    always_comb begin
        dl_rise  = bus.ioctl_download & ~dl_q;
        dl_fall  = ~bus.ioctl_download & dl_q;
        // only strobes inside an open window while loading count
        strobe   = bus.ioctl_wr & bus.ioctl_download & (state == S_LOAD);
        in_range = (bus.ioctl_addr < ADDR_LIMIT);
        ctr_load = (state == S_LOAD) & dl_fall;
        image_ok = (byte_count == EXPECT_COUNT) && !ovf;
`ifdef ROM_LOAD_CHECKSUM_EN
        image_ok = image_ok && (checksum == EXPECT_SUM);
`endif
    end

    rom_load_settle_ctr #(
        .WIDTH (CTR_W)
    ) u_settle_ctr (
        .clk_sys (clk_sys),
        .reset   (reset),
        .load    (ctr_load),
        .init    (SETTLE_INIT),
        .zero    (ctr_zero)
    );

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state         <= S_WAIT;
            dl_q          <= 1'b0;
            ovf           <= 1'b0;
            core_reset    <= 1'b1;
            load_done     <= 1'b0;
            load_error    <= 1'b0;
            byte_count    <= '0;
            bus.dn_wr     <= 1'b0;
            bus.dn_addr   <= '0;
            bus.dn_data   <= '0;
            bus.dn_region <= '0;
`ifdef ROM_LOAD_CHECKSUM_EN
            checksum      <= '0;
`endif
        end else begin
            dl_q      <= bus.ioctl_download;
            bus.dn_wr <= 1'b0;

            if (dl_rise) begin
                state      <= S_LOAD;
                ovf        <= 1'b0;
                core_reset <= 1'b1;
                load_done  <= 1'b0;
                load_error <= 1'b0;
                byte_count <= '0;
`ifdef ROM_LOAD_CHECKSUM_EN
                checksum   <= '0;
`endif
            end else begin
                case (state)
                    S_LOAD: begin
                        if (strobe) begin
                            if (byte_count != COUNT_MAX)
                                byte_count <= byte_count + 1'b1;
                            if (in_range) begin
                                bus.dn_wr     <= 1'b1;
                                bus.dn_addr   <= bus.ioctl_addr[15:0];
                                bus.dn_data   <= bus.ioctl_dout;
                                bus.dn_region <= region_of(bus.ioctl_addr[15:0]);
`ifdef ROM_LOAD_CHECKSUM_EN
                                checksum      <= checksum + bus.ioctl_dout;
`endif
                            end else begin
                                ovf <= 1'b1;
                            end
                        end
                        if (dl_fall)
                            state <= S_SETTLE;
                    end
                    S_SETTLE: begin
                        if (ctr_zero) begin
                            if (image_ok) begin
                                state      <= S_RUN;
                                load_done  <= 1'b1;
                                core_reset <= user_reset;
                            end else begin
                                state      <= S_FAIL;
                                load_error <= 1'b1;
                            end
                        end
                    end
                    S_RUN: begin
                        core_reset <= user_reset;
                    end
                    default: begin
                        core_reset <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rom_load_seq.sv
// Scoreboard bench for rom_load_seq: a small-image instance for sequencing
// and a full-size instance for the region map.
module tb_rom_load_seq;
    import rom_load_pkg::*;

    localparam int S_SET = 16;
    localparam int B_SET = 4;

    logic clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    logic reset;
    logic user_reset;

    rom_load_seq_if bs();
    rom_load_seq_if bb();

    logic        s_core_reset, s_load_done, s_load_error;
    logic [16:0] s_byte_count;
    logic        b_core_reset, b_load_done, b_load_error;
    logic [16:0] b_byte_count;
`ifdef ROM_LOAD_CHECKSUM_EN
    logic [7:0]  s_checksum, b_checksum;
`endif

    rom_load_seq #(
        .EXPECT_BYTES  (32),
        .SETTLE_CYCLES (S_SET)
`ifdef ROM_LOAD_CHECKSUM_EN
        , .EXPECT_SUM  (8'hF0)
`endif
    ) dut_s (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .user_reset (user_reset),
        .bus        (bs),
        .core_reset (s_core_reset),
        .load_done  (s_load_done),
        .load_error (s_load_error),
        .byte_count (s_byte_count)
`ifdef ROM_LOAD_CHECKSUM_EN
        , .checksum (s_checksum)
`endif
    );

    rom_load_seq #(
        .EXPECT_BYTES  (49152),
        .SETTLE_CYCLES (B_SET)
    ) dut_b (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .user_reset (user_reset),
        .bus        (bb),
        .core_reset (b_core_reset),
        .load_done  (b_load_done),
        .load_error (b_load_error),
        .byte_count (b_byte_count)
`ifdef ROM_LOAD_CHECKSUM_EN
        , .checksum (b_checksum)
`endif
    );

    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
        logic [1:0]  r;
        int          due;
    } exp_t;

    exp_t q_s[$];
    exp_t q_b[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always @(posedge clk_sys) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // monitors: every dn_wr must match the oldest outstanding accepted byte
    always @(negedge clk_sys) begin
        exp_t e;
        if (bs.dn_wr === 1'b1) begin
            if (q_s.size() == 0) begin
                chk("s_dn_wr_unexpected", {16'h0, bs.dn_addr}, 32'hFFFF_FFFF);
            end else begin
                e = q_s.pop_front();
                chk("s_dn_addr", {16'h0, bs.dn_addr}, {16'h0, e.a});
                chk("s_dn_data", {24'h0, bs.dn_data}, {24'h0, e.d});
                chk("s_dn_region", {30'h0, bs.dn_region}, {30'h0, e.r});
                chk("s_dn_latency", cyc, e.due);
            end
        end
        if (bb.dn_wr === 1'b1) begin
            if (q_b.size() == 0) begin
                chk("b_dn_wr_unexpected", {16'h0, bb.dn_addr}, 32'hFFFF_FFFF);
            end else begin
                e = q_b.pop_front();
                chk("b_dn_addr", {16'h0, bb.dn_addr}, {16'h0, e.a});
                chk("b_dn_data", {24'h0, bb.dn_data}, {24'h0, e.d});
                chk("b_dn_region", {30'h0, bb.dn_region}, {30'h0, e.r});
                chk("b_dn_latency", cyc, e.due);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic set_dl(input bit big, input logic v);
        if (big) bb.ioctl_download = v;
        else     bs.ioctl_download = v;
    endtask

    task automatic strobe(input bit big, input logic [24:0] a, input logic [7:0] d,
                          input bit acc, input logic [1:0] r, input int gap);
        exp_t e;
        e.a = a[15:0];
        e.d = d;
        e.r = r;
        e.due = cyc + 1;
        if (big) begin
            bb.ioctl_wr = 1'b1; bb.ioctl_addr = a; bb.ioctl_dout = d;
            if (acc) q_b.push_back(e);
        end else begin
            bs.ioctl_wr = 1'b1; bs.ioctl_addr = a; bs.ioctl_dout = d;
            if (acc) q_s.push_back(e);
        end
        tick(1);
        bs.ioctl_wr = 1'b0;
        bb.ioctl_wr = 1'b0;
        tick(gap);
    endtask

    task automatic load_small(input int n, input int gap);
        for (int i = 0; i < n; i++)
            strobe(1'b0, 25'(i), 8'(3 * i + 1), 1'b1, 2'd0, gap);
    endtask

    function automatic logic [31:0] st(input bit big);
        return big ? 32'(dut_b.state) : 32'(dut_s.state);
    endfunction

    // close the window now and follow SETTLE to its decision
    task automatic settle(input bit big, input int s, input bit ok, input string tag);
        set_dl(big, 1'b0);
        tick(1);
        bs.ioctl_wr = 1'b0;
        bb.ioctl_wr = 1'b0;
        chk({tag, "_settle_entry"}, st(big), 32'(S_SETTLE));
        tick(s - 1);
        chk({tag, "_settle_last"}, st(big), 32'(S_SETTLE));
        chk({tag, "_done_early"}, 32'(big ? b_load_done : s_load_done), 32'd0);
        chk({tag, "_core_rst_held"}, 32'(big ? b_core_reset : s_core_reset), 32'd1);
        tick(1);
        chk({tag, "_decision"}, st(big), ok ? 32'(S_RUN) : 32'(S_FAIL));
        chk({tag, "_load_done"}, 32'(big ? b_load_done : s_load_done), 32'(ok));
        chk({tag, "_load_error"}, 32'(big ? b_load_error : s_load_error), 32'(!ok));
        chk({tag, "_core_reset"}, 32'(big ? b_core_reset : s_core_reset), 32'(!ok));
    endtask

    logic [15:0] reg_addr [8];
    logic [1:0]  reg_exp  [8];

    initial begin
        reg_addr = '{16'h0000, 16'h5FFF, 16'h6000, 16'h7FFF,
                     16'h8000, 16'h9FFF, 16'hA000, 16'hBFFF};
        reg_exp  = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};

        bs.ioctl_download = 0; bs.ioctl_wr = 0; bs.ioctl_addr = '0; bs.ioctl_dout = '0;
        bb.ioctl_download = 0; bb.ioctl_wr = 0; bb.ioctl_addr = '0; bb.ioctl_dout = '0;
        user_reset = 1'b0;
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(100);

        chk("rst_state", st(0), 32'(S_WAIT));
        chk("rst_core_reset", 32'(s_core_reset), 32'd1);
        chk("rst_load_done", 32'(s_load_done), 32'd0);
        chk("rst_load_error", 32'(s_load_error), 32'd0);
        chk("rst_byte_count", 32'(s_byte_count), 32'd0);
        chk("rst_dn_addr", 32'(bs.dn_addr), 32'd0);
        chk("rst_dn_data", 32'(bs.dn_data), 32'd0);
        chk("rst_dn_region", 32'(bs.dn_region), 32'd0);
        chk("rst_big_core_reset", 32'(b_core_reset), 32'd1);

        // strobe with the window closed must not write
        strobe(1'b0, 25'd5, 8'hAA, 1'b0, 2'd0, 1);

        // valid back-to-back load
        set_dl(0, 1'b1);
        tick(2);
        chk("valid_state_load", st(0), 32'(S_LOAD));
        load_small(32, 0);
        settle(0, S_SET, 1'b1, "valid");
        chk("valid_byte_count", 32'(s_byte_count), 32'd32);
`ifdef ROM_LOAD_CHECKSUM_EN
        chk("valid_checksum", 32'(s_checksum), 32'hF0);
`endif

        // user_reset in RUN appears on core_reset one cycle late
        chk("ur_before", 32'(s_core_reset), 32'd0);
        user_reset = 1'b1;
        tick(1); chk("ur_c1", 32'(s_core_reset), 32'd1);
        tick(1); chk("ur_c2", 32'(s_core_reset), 32'd1);
        tick(1); chk("ur_c3", 32'(s_core_reset), 32'd1);
        user_reset = 1'b0;
        tick(1); chk("ur_c4", 32'(s_core_reset), 32'd0);
        tick(1); chk("ur_c5", 32'(s_core_reset), 32'd0);
        chk("ur_still_run", st(0), 32'(S_RUN));

        // reload: clears status; 31 bytes every 4 cycles, 32nd on the closing edge
        set_dl(0, 1'b1);
        tick(2);
        chk("reload_state", st(0), 32'(S_LOAD));
        chk("reload_load_done", 32'(s_load_done), 32'd0);
        chk("reload_byte_count", 32'(s_byte_count), 32'd0);
        chk("reload_core_reset", 32'(s_core_reset), 32'd1);
        load_small(31, 3);
        bs.ioctl_wr = 1'b1; bs.ioctl_addr = 25'd31; bs.ioctl_dout = 8'd94;
        settle(0, S_SET, 1'b0, "short");
        chk("short_byte_count", 32'(s_byte_count), 32'd31);

        // overflow: full image, one past the end, one aliasing into low 16 bits
        set_dl(0, 1'b1);
        tick(2);
        chk("ovf_clears_error", 32'(s_load_error), 32'd0);
        load_small(32, 0);
        strobe(1'b0, 25'd32, 8'h77, 1'b0, 2'd0, 0);
        strobe(1'b0, 25'h0010000, 8'h66, 1'b0, 2'd0, 0);
        settle(0, S_SET, 1'b0, "ovf");
        chk("ovf_byte_count", 32'(s_byte_count), 32'd34);

        // new rising edge during SETTLE restarts LOAD at once
        set_dl(0, 1'b1);
        tick(2);
        load_small(32, 1);
        set_dl(0, 1'b0);
        tick(5);
        chk("restart_in_settle", st(0), 32'(S_SETTLE));
        set_dl(0, 1'b1);
        tick(1);
        chk("restart_state", st(0), 32'(S_LOAD));
        chk("restart_byte_count", 32'(s_byte_count), 32'd0);
        tick(1);
        load_small(32, 0);
        settle(0, S_SET, 1'b1, "restart");
`ifdef ROM_LOAD_CHECKSUM_EN
        chk("restart_checksum", 32'(s_checksum), 32'hF0);
`endif

        // reset in the middle of a load
        set_dl(0, 1'b1);
        tick(2);
        load_small(10, 0);
        tick(2);
        reset = 1'b1;
        bs.ioctl_download = 1'b0;
        tick(2);
        reset = 1'b0;
        tick(1);
        chk("midrst_state", st(0), 32'(S_WAIT));
        chk("midrst_byte_count", 32'(s_byte_count), 32'd0);
        chk("midrst_core_reset", 32'(s_core_reset), 32'd1);
        chk("midrst_load_done", 32'(s_load_done), 32'd0);
        for (int i = 0; i < 3; i++)
            strobe(1'b0, 25'(11 + i), 8'h55, 1'b0, 2'd0, 0);
        tick(2);
        chk("midrst_ignored_state", st(0), 32'(S_WAIT));
        chk("midrst_ignored_count", 32'(s_byte_count), 32'd0);

        // full-size instance: region boundaries and overflow at 0xC000
        set_dl(1, 1'b1);
        tick(2);
        for (int i = 0; i < 8; i++)
            strobe(1'b1, {9'h0, reg_addr[i]}, 8'(17 * i + 3), 1'b1, reg_exp[i], 1);
        strobe(1'b1, 25'h000C000, 8'hEE, 1'b0, 2'd0, 0);
        settle(1, B_SET, 1'b0, "big");
        chk("big_byte_count", 32'(b_byte_count), 32'd9);

        tick(3);
        chk("s_queue_drained", q_s.size(), 32'd0);
        chk("b_queue_drained", q_b.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
